mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

MEM-stage data-memory access sequencer for the pipelined LC-3b datapath. Translates the MEM-stage memory opcode into D-cache read/write requests and drives byte lanes. Runs the two-access LDI/STI sequence and raises the indirect stall request consumed by the stall/hazard unit. Sits between the EX/MEM pipeline register and the D-cache port; its read/write strobes are also the data-miss inputs to the hazard unit.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data word width
- clk  input  1  pipeline clock
- rst_n  input  1  reset, asynchronous, active-low
- valid_in  input  1  MEM stage holds a live instruction
- op  input  mem_op_t  NONE, LDW, LDB, STW, STB, LDI, STI
- addr_in  input  ADDR_W  effective address from EX/MEM register
- store_data  input  DATA_W  SR value for stores
- mem_rdata  input  DATA_W  D-cache read data
- mem_resp  input  1  D-cache response, valid same cycle
- mem_address  output  ADDR_W  D-cache address
- mem_read  output  1  D-cache read strobe; also hazard-unit mem_memread
- mem_write  output  1  D-cache write strobe; also hazard-unit mem_memwrite
- mem_wdata  output  DATA_W  D-cache write data
- mem_byte_enable  output  2  byte lanes {hi, lo}
- load_data  output  DATA_W  load result to MEM/WB register
- sti_ldi_sig  output  1  indirect stall request to hazard unit (stalls all stages)

## Operation
- FSM states: PTR (default, reset state), DATA.
- PTR, valid_in=0 or op=NONE: all strobes 0, byte_enable 2'b00.
- PTR, LDW/STW: one access at {addr_in[15:1],1'b0}; byte_enable 2'b11; STW wdata = store_data.
- PTR, LDB/STB: access at addr_in; byte_enable = addr_in[0] ? 2'b10 : 2'b01; STB wdata = {store_data[7:0], store_data[7:0]}; LDB load_data = sign-extended selected byte.
- PTR, LDI/STI: mem_read=1 at {addr_in[15:1],1'b0}, sti_ldi_sig=1 for every cycle in PTR. On mem_resp=1: ptr_q <= {mem_rdata[15:1],1'b0}, next state DATA.
- DATA: sti_ldi_sig=0; access at ptr_q, byte_enable 2'b11; LDI reads (load_data = mem_rdata), STI writes store_data. Stall until resp comes from the hazard unit's data-miss path. On mem_resp=1 return to PTR.
- load_data is combinational from mem_rdata; valid only in the completing resp cycle. Otherwise 16'h0000.
- Outputs never depend on state for non-indirect ops; single-access ops never leave PTR.
- mem_resp while no strobe is active: ignored, no state change.
- valid_in dropping in DATA (unexpected flush): return to PTR next cycle, no access issued.

## Timing
- Reset (async assert): state=PTR, ptr_q=0. All outputs 0 while rst_n=0 regardless of inputs.
- Single access, hit: 1 cycle. Miss: strobe held with constant address/data until the resp cycle.
- LDI/STI, both hits: 2 cycles (PTR resp, DATA resp). General: pointer latency + data latency, no idle cycle between.
- The pipeline advances only on the DATA resp cycle. sti_ldi_sig covers the PTR resp cycle, so the hazard unit never releases after the pointer fetch.
- Reset mid-sequence: abandons the access immediately; the instruction replays from PTR after reset.

## Configuration
- MEM_SEQ_INDIRECT_EN defined: LDI/STI two-access sequence as above.
- Undefined: no DATA state, no ptr_q. LDI behaves as LDW, STI as STW. sti_ldi_sig tied 0.

## Structure
- Shared package (lc3b_types): mem_op_t enum, ADDR_W/DATA_W constants, byte-enable constants (BE_WORD, BE_LO, BE_HI).
- One sub-module: mem_byte_lane (combinational): byte_enable, wdata replication, LDB select/sign-extend. The FSM and ptr_q stay in the top.

## Test plan
- Reset: assert rst_n=0 mid-DATA -> state PTR, mem_read/mem_write/sti_ldi_sig=0 asynchronously.
- LDW addr 16'h3001, resp held 0 for 3 cycles then 1 with rdata 16'hBEEF -> mem_address 16'h3000 constant, mem_read high 4 cycles, load_data 16'hBEEF in the resp cycle.
- STB addr 16'h4005, store_data 16'h12A7 -> byte_enable 2'b10, wdata 16'hA7A7, mem_write=1. LDB addr 16'h4004 with rdata 16'h0080 -> load_data 16'hFF80.
- LDI addr 16'h2000, mem[16'h2000]=16'h5003, mem[16'h5002]=16'h1234, all hits -> cycle 0 sti_ldi_sig=1 at 16'h2000; cycle 1 sti_ldi_sig=0, address 16'h5002, load_data 16'h1234.
- STI with pointer miss of 2 cycles and data miss of 3 cycles -> sti_ldi_sig high 3 cycles, then mem_write high 4 cycles at the pointer, total 7 cycles.
- MEM_SEQ_INDIRECT_EN undefined: LDI addr 16'h2000 -> single read, load_data = mem[16'h2000], sti_ldi_sig never 1.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b MEM-stage types: memory opcodes, widths, byte-enable codes and
// the sequencer state encoding.
package lc3b_types;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        NONE,
        LDW,
        LDB,
        STW,
        STB,
        LDI,
        STI
    } mem_op_t;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    typedef enum logic {
        PTR,
        DATA
    } seq_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_access_sequencer_byte_lane.sv
// Byte-lane steering for D-cache accesses: lane enables, store-byte
// replication and load-byte select with sign extension.
module mem_byte_lane
    import lc3b_types::*;
(
    input  logic              byte_op,
    input  logic              addr_lsb,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [1:0]        byte_enable,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_word
);

    logic [7:0] sel_byte;

    // A byte store drives the same byte onto both lanes; the enable picks one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign wdata[gi*8 +: 8] = byte_op ? store_data[7:0] : store_data[gi*8 +: 8];
        end
    endgenerate

    assign byte_enable = !byte_op ? BE_WORD : (addr_lsb ? BE_HI : BE_LO);
    assign sel_byte    = addr_lsb ? rdata[15:8] : rdata[7:0];
    assign load_word   = byte_op ? {{(DATA_W-8){sel_byte[7]}}, sel_byte} : rdata;

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage D-cache access sequencer. Define MEM_SEQ_INDIRECT_EN to enable the
// two-access LDI/STI sequence; otherwise LDI/STI act as LDW/STW.
module mem_access_sequencer
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  mem_op_t           op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_byte_enable,
    output logic [DATA_W-1:0] load_data,
    output logic              sti_ldi_sig
);

    logic              byte_op;
    logic              is_load;
    logic              is_store;
    logic [1:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;

    assign byte_op = (op == LDB) || (op == STB);

`ifdef MEM_SEQ_INDIRECT_EN
    logic              is_ind;
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    assign is_load  = (op == LDW) || (op == LDB);
    assign is_store = (op == STW) || (op == STB);
    assign is_ind   = (op == LDI) || (op == STI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PTR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
`else
    assign is_load  = (op == LDW) || (op == LDB) || (op == LDI);
    assign is_store = (op == STW) || (op == STB) || (op == STI);
`endif

    mem_byte_lane u_byte_lane (
        .byte_op     (byte_op),
        .addr_lsb    (addr_in[0]),
        .store_data  (store_data),
        .rdata       (mem_rdata),
        .byte_enable (lane_be),
        .wdata       (lane_wdata),
        .load_word   (lane_load)
    );

    always_comb begin
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = '0;
        mem_byte_enable = BE_NONE;
        load_data       = '0;
        sti_ldi_sig     = 1'b0;
`ifdef MEM_SEQ_INDIRECT_EN
        state_d         = state_q;
        ptr_d           = ptr_q;
`endif
        // Gating on rst_n keeps every output low while reset is held.
        if (rst_n && valid_in) begin
`ifdef MEM_SEQ_INDIRECT_EN
            if (state_q == DATA) begin
                mem_address     = ptr_q;
                mem_byte_enable = BE_WORD;
                if (op == LDI) begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_data = mem_rdata;
                    end
                end else if (op == STI) begin
                    mem_write = 1'b1;
                    mem_wdata = store_data;
                end
                if (mem_resp || !is_ind) begin
                    state_d = PTR;
                end
            end else if (is_ind) begin
                // Stall request stays up through the pointer resp cycle.
                mem_address     = word_align(addr_in);
                mem_read        = 1'b1;
                mem_byte_enable = BE_WORD;
                sti_ldi_sig     = 1'b1;
                if (mem_resp) begin
                    ptr_d   = word_align(mem_rdata);
                    state_d = DATA;
                end
            end else
`endif
            if (is_load) begin
                mem_address     = byte_op ? addr_in : word_align(addr_in);
                mem_read        = 1'b1;
                mem_byte_enable = lane_be;
                if (mem_resp) begin
                    load_data = lane_load;
                end
            end else if (is_store) begin
                mem_address     = byte_op ? addr_in : word_align(addr_in);
                mem_write       = 1'b1;
                mem_byte_enable = lane_be;
                mem_wdata       = lane_wdata;
            end
        end
`ifdef MEM_SEQ_INDIRECT_EN
        // A flush in DATA abandons the indirect access.
        if (!valid_in && state_q == DATA) begin
            state_d = PTR;
        end
`endif
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer with a word-memory reference model.
module tb_mem_access_sequencer;
    import lc3b_types::*;

`ifdef MEM_SEQ_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    mem_op_t     op;
    logic [15:0] addr_in;
    logic [15:0] store_data;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] load_data;
    logic        sti_ldi_sig;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [logic [15:0]];

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic        sti;
        logic        chk_be;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        last;
    } acc_t;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .op              (op),
        .addr_in         (addr_in),
        .store_data      (store_data),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .load_data       (load_data),
        .sti_ldi_sig     (sti_ldi_sig)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:1], 1'b0};
        if (mem.exists(w)) return mem[w];
        return 16'(w * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic write_mem(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] w, old;
        w   = {a[15:1], 1'b0};
        old = rd_word(w);
        if (be == 2'b11)      mem[w] = d;
        else if (be == 2'b10) mem[w] = {d[15:8], old[7:0]};
        else                  mem[w] = {old[15:8], d[7:0]};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"},   mem_read, 0);
        chk({tag, "_wr"},   mem_write, 0);
        chk({tag, "_sti"},  sti_ldi_sig, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_be"},   mem_byte_enable, 0);
        chk({tag, "_load"}, load_data, 0);
    endtask

    // One instruction from MEM entry to completion; lat<0 picks a random miss length.
    task automatic do_op(input mem_op_t o, input logic [15:0] a, input logic [15:0] sd,
                         input int lat0, input int lat1);
        acc_t        q[$];
        acc_t        x;
        logic [15:0] res, w, ptr, word;
        logic [7:0]  b;
        logic        ld;
        bit          ind;
        int          lat;
        int          cycles;
        ind    = IND && (o == LDI || o == STI);
        w      = {a[15:1], 1'b0};
        ld     = (o == LDW || o == LDB || o == LDI);
        cycles = 0;
        x      = '0;
        x.last = 1'b1; x.chk_be = 1'b1; x.be = 2'b11;
        if (ind) begin
            ptr = rd_word(a) & 16'hFFFE;
            x.addr = w; x.rd = 1'b1; x.sti = 1'b1; x.chk_be = 1'b0; x.last = 1'b0;
            q.push_back(x);
            x = '0;
            x.last = 1'b1; x.chk_be = 1'b1; x.be = 2'b11;
            x.addr = ptr; x.rd = ld; x.wr = !ld; x.wdata = sd;
            q.push_back(x);
            res = rd_word(ptr);
        end else if (o == LDB || o == STB) begin
            x.addr = a; x.be = a[0] ? 2'b10 : 2'b01;
            x.rd = (o == LDB); x.wr = (o == STB); x.wdata = {sd[7:0], sd[7:0]};
            q.push_back(x);
            word = rd_word(a);
            b    = a[0] ? word[15:8] : word[7:0];
            res  = {{8{b[7]}}, b};
        end else begin
            x.addr = w; x.rd = ld; x.wr = !ld; x.wdata = sd;
            q.push_back(x);
            res = rd_word(a);
        end
        foreach (q[i]) begin
            lat = (i == 0) ? lat0 : lat1;
            if (lat < 0) lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                valid_in   = 1'b1;
                op         = o;
                addr_in    = a;
                store_data = sd;
                mem_resp   = (c == lat);
                mem_rdata  = mem_resp ? rd_word(q[i].addr) : 16'($urandom);
                @(negedge clk);
                chk("addr", mem_address, q[i].addr);
                chk("read", mem_read, q[i].rd);
                chk("write", mem_write, q[i].wr);
                chk("sti_ldi", sti_ldi_sig, q[i].sti);
                if (q[i].chk_be) chk("byte_en", mem_byte_enable, q[i].be);
                if (q[i].wr) chk("wdata", mem_wdata, q[i].wdata);
                chk("load_data", load_data, (mem_resp && q[i].last && ld) ? res : 16'h0);
                if (mem_resp && q[i].wr) write_mem(q[i].addr, q[i].be, q[i].wdata);
                cycles++;
                @(posedge clk); #1;
            end
        end
        $display("txn %s addr=%h sd=%h cycles=%0d result=%h", o.name(), a, sd, cycles,
                 ld ? res : 16'h0);
    endtask

    task automatic idle_cycle(input logic v);
        valid_in   = v;
        op         = v ? NONE : mem_op_t'($urandom_range(0, 6));
        addr_in    = 16'($urandom);
        store_data = 16'($urandom);
        mem_resp   = 1'($urandom);
        mem_rdata  = 16'($urandom);
        @(negedge clk);
        chk_quiet(v ? "op_none" : "idle");
        @(posedge clk); #1;
    endtask

`ifdef MEM_SEQ_INDIRECT_EN
    task automatic ptr_hit(input logic [15:0] a);
        valid_in  = 1'b1;
        op        = LDI;
        addr_in   = a;
        mem_resp  = 1'b1;
        mem_rdata = rd_word(a);
        @(negedge clk);
        chk("ptr_sti", sti_ldi_sig, 1);
        chk("ptr_read", mem_read, 1);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b1;
        op         = LDW;
        addr_in    = 16'h3001;
        store_data = 16'hFFFF;
        mem_resp   = 1'b1;
        mem_rdata  = 16'hFFFF;
        #2;
        chk_quiet("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem[16'h3000] = 16'hBEEF;
        do_op(LDW, 16'h3001, 16'h0000, 3, 0);
        do_op(STB, 16'h4005, 16'h12A7, 0, 0);
        mem[16'h4004] = 16'h0080;
        do_op(LDB, 16'h4004, 16'h0000, 0, 0);
        mem[16'h2000] = 16'h5003;
        mem[16'h5002] = 16'h1234;
        do_op(LDI, 16'h2000, 16'h0000, 0, 0);
        mem[16'h2100] = 16'h6001;
        do_op(STI, 16'h2100, 16'hCAFE, 2, 3);
        do_op(LDW, 16'h6001, 16'h0000, 0, 0);

        // Asynchronous reset while an access is in flight.
`ifdef MEM_SEQ_INDIRECT_EN
        ptr_hit(16'h2000);
        op = LDI;
`else
        op = LDW;
`endif
        valid_in = 1'b1;
        addr_in  = 16'h2000;
        mem_resp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        @(negedge clk);
        chk_quiet("rst_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(LDI, 16'h2000, 16'h0000, 1, 0);

`ifdef MEM_SEQ_INDIRECT_EN
        ptr_hit(16'h2100);
        valid_in  = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 16'($urandom);
        @(negedge clk);
        chk_quiet("flush");
        @(posedge clk); #1;
`endif
        do_op(LDW, 16'h0102, 16'h0000, 0, 0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 5) == 0) idle_cycle(1'($urandom));
            do_op(mem_op_t'($urandom_range(1, 6)),
                  16'($urandom_range(0, 63)) | (16'($urandom_range(0, 3)) << 12),
                  16'($urandom), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
